// File: rtl/spi_ram_burst_slave.sv
// spi_ram_burst_slave
//   SPI-framed RAM slave with an internal single-port memory. A frame opens
//   with a 2-bit command, then carries an address or a burst of data words.
//   Pointers optionally auto-increment per word, so one frame can stream
//   many words.
//
// Ports
//   clk       system clock, one serial bit per rising edge
//   rst_n     synchronous active-low reset (memory contents are kept)
//   SS_n      slave select, active low, frames a transaction
//   MOSI      serial data in, MSB first
//   MISO      serial data out, MSB first, registered
//   busy      high while a frame is in progress
//   frame_err one-cycle pulse when a frame ends in the middle of a field
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for SS_n low after having seen it high (armed)
// CMD     | shifting the 2 command bits
// WR_ADDR | shifting the write address, extra bits ignored
// WR_DATA | shifting write words, committing each complete word
// RD_ADDR | shifting the read address, extra bits ignored
// RD_TURN | one turnaround cycle, fetch mem[rd_ptr]
// RD_DATA | streaming read words on MISO
module spi_ram_burst_slave #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter bit AUTO_INC   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW    = $clog2(MAXW + 1);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CW-1:0] ALAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DLAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_TURN, RD_DATA
  } state_t;

  state_t state, state_nxt;

  logic                  armed;
  logic [CW-1:0]         bit_cnt;
  logic                  addr_done;
  logic [MAXW-2:0]       sr;        // previously received bits; MOSI supplies the newest
  logic [DATA_WIDTH-1:0] tx;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] rx_word;
  logic [ADDR_WIDTH-1:0] rx_addr;
  logic [ADDR_WIDTH-1:0] wr_next, rd_next;
  logic                  err_now, addr_last, word_last, mem_we;

  // The field being completed on this edge is the shift register plus MOSI.
  assign rx_word = DATA_WIDTH'({sr, MOSI});
  assign rx_addr = ADDR_WIDTH'({sr, MOSI});
  assign wr_next = AUTO_INC ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_next = AUTO_INC ? rd_ptr + 1'b1 : rd_ptr;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (!SS_n && armed) state_nxt = CMD;
    end else if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        CMD: begin
          if (bit_cnt == CW'(1)) begin
            case ({sr[0], MOSI})
              2'b00:   state_nxt = WR_ADDR;
              2'b01:   state_nxt = WR_DATA;
              2'b10:   state_nxt = RD_ADDR;
              default: state_nxt = RD_TURN;
            endcase
          end
        end
        RD_TURN: state_nxt = RD_DATA;
        default: state_nxt = state;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    busy      = (state != IDLE);
    err_now   = (state != IDLE) && SS_n && (bit_cnt != '0);
    addr_last = ((state == WR_ADDR) || (state == RD_ADDR)) && !SS_n &&
                !addr_done && (bit_cnt == ALAST);
    word_last = ((state == WR_DATA) || (state == RD_DATA)) && !SS_n &&
                (bit_cnt == DLAST);
    // rst_n gate keeps a reset edge from committing a word.
    mem_we    = rst_n && (state == WR_DATA) && word_last;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      frame_err <= 1'b0;
      MISO      <= 1'b0;
      bit_cnt   <= '0;
      addr_done <= 1'b0;
      sr        <= '0;
      tx        <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      armed     <= armed | SS_n;
      frame_err <= err_now;
      MISO      <= 1'b0;
      if ((state == IDLE) || SS_n) begin
        bit_cnt   <= '0;
        addr_done <= 1'b0;
      end else begin
        case (state)
          CMD: begin
            sr      <= (MAXW-1)'({sr, MOSI});
            bit_cnt <= (bit_cnt == CW'(1)) ? '0 : bit_cnt + CW'(1);
          end
          WR_ADDR, RD_ADDR: begin
            if (!addr_done) begin
              sr <= (MAXW-1)'({sr, MOSI});
              if (addr_last) begin
                bit_cnt   <= '0;
                addr_done <= 1'b1;
                if (state == WR_ADDR) wr_ptr <= rx_addr;
                else                  rd_ptr <= rx_addr;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
          WR_DATA: begin
            sr <= (MAXW-1)'({sr, MOSI});
            if (word_last) begin
              bit_cnt <= '0;
              wr_ptr  <= wr_next;
            end else begin
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          RD_TURN: begin
            tx      <= mem[rd_ptr];
            bit_cnt <= '0;
          end
          RD_DATA: begin
            MISO <= tx[DATA_WIDTH-1];
            if (word_last) begin
              // Load the following word while its predecessor's LSB goes out,
              // so the next MSB follows with no gap.
              bit_cnt <= '0;
              tx      <= mem[rd_next];
              rd_ptr  <= rd_next;
            end else begin
              tx      <= tx << 1;
              bit_cnt <= bit_cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= rx_word;
  end

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
module tb_spi_ram_burst_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss0 = 1'b1, ss1 = 1'b1, mosi = 1'b0;
  logic miso0, busy0, err0, miso1, busy1, err1;
  int   pass_cnt = 0, fail_cnt = 0, total = 0;
  int   sel = 0;
  int   seen_busy;

  always #5 clk = ~clk;

  spi_ram_burst_slave dut0 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss0), .MOSI(mosi),
    .MISO(miso0), .busy(busy0), .frame_err(err0)
  );

  spi_ram_burst_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .AUTO_INC(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss1), .MOSI(mosi),
    .MISO(miso1), .busy(busy1), .frame_err(err1)
  );

  function automatic logic cur_miso();
    return (sel == 0) ? miso0 : miso1;
  endfunction
  function automatic logic cur_busy();
    return (sel == 0) ? busy0 : busy1;
  endfunction
  function automatic logic cur_err();
    return (sel == 0) ? err0 : err1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One serial bit: drive at the falling edge, return 1 time unit after the rising edge.
  task automatic drv(input logic s, input logic m);
    @(negedge clk);
    if (sel == 0) begin ss0 = s; ss1 = 1'b1; end
    else          begin ss1 = s; ss0 = 1'b1; end
    mosi = m;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) drv(1'b0, v[i]);
  endtask

  task automatic begin_frame(input logic [1:0] c);
    drv(1'b1, 1'b0);
    drv(1'b0, 1'b0);
    send({30'd0, c}, 2);
  endtask

  task automatic end_frame();
    drv(1'b1, 1'b0);
  endtask

  task automatic wr_frame(input logic [1:0] c, input logic [31:0] v, input int n, input string tag);
    begin_frame(c);
    send(v, n);
    end_frame();
    chk($sformatf("%s_err", tag), cur_err(), 0);
    chk($sformatf("%s_busy", tag), cur_busy(), 0);
  endtask

  task automatic rd_burst(input int w, input int nw, input logic [31:0] e0,
                          input logic [31:0] e1, input logic [31:0] e2,
                          input bit bitchk, input string tag);
    logic [31:0] got, exp_w;
    begin_frame(2'b11);
    drv(1'b0, 1'b0);
    chk($sformatf("%s_turn", tag), cur_miso(), 0);
    for (int n = 0; n < nw; n++) begin
      exp_w = (n == 0) ? e0 : (n == 1) ? e1 : e2;
      got = '0;
      for (int k = 1; k <= w; k++) begin
        drv(1'b0, 1'b0);
        got = {got[30:0], cur_miso()};
        if (bitchk) chk($sformatf("%s_b%0d", tag, k), cur_miso(), exp_w[w-k]);
      end
      chk($sformatf("%s_w%0d", tag, n), got, exp_w);
    end
    end_frame();
    chk($sformatf("%s_err", tag), cur_err(), 0);
    chk($sformatf("%s_miso_end", tag), cur_miso(), 0);
  endtask

  initial begin
    // Reset with SS_n low, then 20 more cycles low after release.
    sel = 0;
    for (int i = 0; i < 3; i++) drv(1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    seen_busy = 0;
    for (int i = 0; i < 20; i++) begin
      drv(1'b0, 1'b1);
      if (busy0 !== 1'b0 || miso0 !== 1'b0) seen_busy++;
    end
    chk("rst_idle_20", seen_busy, 0);
    chk("rst_wr_ptr", dut0.wr_ptr, 0);
    chk("rst_rd_ptr", dut0.rd_ptr, 0);

    // SS_n high one edge, then low: frame accepted. WR_ADDR 0x10.
    drv(1'b1, 1'b0);
    drv(1'b0, 1'b0);
    chk("start_busy", busy0, 1);
    send(32'd0, 2);
    send(32'h10, 8);
    end_frame();
    chk("wa10_err", err0, 0);
    chk("wa10_ptr", dut0.wr_ptr, 8'h10);

    wr_frame(2'b01, 32'hA5, 8, "wd_a5");
    chk("mem10", dut0.mem[8'h10], 8'hA5);
    wr_frame(2'b10, 32'h10, 8, "ra10");
    rd_burst(8, 1, 32'hA5, 0, 0, 1'b1, "rd_a5");

    // Burst write with pointer wrap.
    wr_frame(2'b00, 32'hFE, 8, "wa_fe");
    begin_frame(2'b01);
    send(32'h11, 8);
    chk("lat_memfe", dut0.mem[8'hFE], 8'h11);
    send(32'h22, 8);
    send(32'h33, 8);
    end_frame();
    chk("burst_err", err0, 0);
    chk("memff", dut0.mem[8'hFF], 8'h22);
    chk("mem00", dut0.mem[8'h00], 8'h33);
    chk("wrap_ptr", dut0.wr_ptr, 8'h01);
    wr_frame(2'b10, 32'hFE, 8, "ra_fe");
    rd_burst(8, 3, 32'h11, 32'h22, 32'h33, 1'b0, "rd_wrap");

    // Abort handling.
    wr_frame(2'b00, 32'h21, 8, "wa21");
    wr_frame(2'b01, 32'h77, 8, "wd77");
    wr_frame(2'b00, 32'h21, 8, "wa21b");
    begin_frame(2'b01);
    send(32'h1F, 5);
    drv(1'b1, 1'b0);
    chk("abort_err_hi", err0, 1);
    chk("abort_busy", busy0, 0);
    drv(1'b1, 1'b0);
    chk("abort_err_lo", err0, 0);
    chk("abort_mem", dut0.mem[8'h21], 8'h77);
    chk("abort_ptr", dut0.wr_ptr, 8'h21);
    wr_frame(2'b01, 32'hC3, 8, "wd_c3");
    chk("full_mem", dut0.mem[8'h21], 8'hC3);
    chk("full_ptr", dut0.wr_ptr, 8'h22);

    // Second instance: AUTO_INC=0, 4-bit address, 16-bit data.
    sel = 1;
    wr_frame(2'b00, 32'h3, 4, "n_wa3");
    begin_frame(2'b01);
    send(32'h1234, 16);
    chk("n_mem3_a", dut1.mem[3], 16'h1234);
    send(32'hBEEF, 16);
    end_frame();
    chk("n_err", err1, 0);
    chk("n_mem3_b", dut1.mem[3], 16'hBEEF);
    chk("n_ptr", dut1.wr_ptr, 4'h3);
    wr_frame(2'b10, 32'h3, 4, "n_ra3");
    rd_burst(16, 2, 32'hBEEF, 32'hBEEF, 0, 1'b0, "n_rd");
    sel = 0;

    // Reset in the middle of a burst read.
    wr_frame(2'b10, 32'h10, 8, "ra10b");
    begin_frame(2'b11);
    drv(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drv(1'b0, 1'b0);
    chk("mid_rd_bit3", miso0, 1);
    drv(1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_miso", miso0, 0);
    chk("mrst_busy", busy0, 0);
    chk("mrst_err", err0, 0);
    chk("mrst_wr_ptr", dut0.wr_ptr, 0);
    chk("mrst_rd_ptr", dut0.rd_ptr, 0);
    @(negedge clk) rst_n = 1'b1;
    wr_frame(2'b00, 32'h05, 8, "post_wa");
    wr_frame(2'b01, 32'h3C, 8, "post_wd");
    wr_frame(2'b10, 32'h05, 8, "post_ra");
    rd_burst(8, 1, 32'h3C, 0, 0, 1'b0, "post_rd");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst_slave.md
# spi_ram_burst_slave

Parametrised SPI-framed RAM slave, the next generation of the team's single-word SPI_slave + RAM pair. One module: serial frame decoder plus internal single-port memory, generalised in address and data width. Adds auto-incrementing burst writes and reads within one SS_n assertion, and explicit abort detection. Sits between the board SPI pins and any on-chip consumer of the configuration RAM.

## Interface
- ADDR_WIDTH, 8, address bits; memory depth = 2**ADDR_WIDTH
- DATA_WIDTH, 8, bits per memory word
- AUTO_INC, 1, 1: pointers increment after each data word; 0: pointers hold
- clk  in  1  system clock, one serial bit per rising edge
- rst_n  in  1  synchronous, active-low reset
- SS_n  in  1  slave select, active low; low frames a transaction
- MOSI  in  1  serial data in, MSB first
- MISO  out  1  serial data out, MSB first, registered
- busy  out  1  high while a frame is in progress (state != IDLE)
- frame_err  out  1  one-cycle pulse on aborted frame

## Operation
- Commands (first 2 bits): 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
- States: IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_TURN, RD_DATA.
- IDLE -> CMD on an edge with SS_n=0 and armed=1. MOSI is not sampled on this start edge. armed is set by any edge with SS_n=1 and cleared on reset.
- CMD: samples 2 bits, then moves to the decoded state. RD_DATA command goes to RD_TURN.
- WR_ADDR / RD_ADDR: shift ADDR_WIDTH bits; on the edge sampling the last bit, load wr_ptr / rd_ptr. Extra bits while SS_n stays low are ignored. State holds until SS_n goes high.
- WR_DATA burst: shift DATA_WIDTH bits; on the edge sampling the last bit, write mem[wr_ptr]. If AUTO_INC, wr_ptr <= wr_ptr+1 modulo depth. The next DATA_WIDTH bits form the next word, no command re-sent. Repeats until SS_n high.
- RD_TURN: one cycle; fetch mem[rd_ptr].
- RD_DATA burst: drive the word MSB first for DATA_WIDTH cycles. The next word (rd_ptr+1 if AUTO_INC, else same) follows with no gap; the implementation prefetches. MOSI is ignored.
- SS_n=1 in any non-IDLE state -> IDLE on that edge; MISO <= 0.
  - frame_err pulses if the bit count in the current command/address/word is nonzero.
  - A partial word is discarded: no write, pointers unchanged.
  - A burst ending exactly on a word boundary is not an error.
- Memory is not cleared by reset. A read in a later frame returns the latest write.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, wr_ptr=0, rd_ptr=0, armed=0, MISO=0, busy=0, frame_err=0. Applies mid-frame; the aborted frame has no effect and frame_err does not pulse.
- After reset, SS_n must be seen high at least one edge before a frame starts.
- Edge numbering: S = start edge, E1, E2 = command bits, E3.. = payload.
- Write latency: mem[wr_ptr] is updated at edge E(2+DATA_WIDTH). Burst word n is committed at E(2+n*DATA_WIDTH).
- Read: E3 = turnaround. After edge E(3+k), k=1..DATA_WIDTH, MISO = bit DATA_WIDTH-k of word 0. Word n bit k appears after E(3+n*DATA_WIDTH+k).
- busy rises after S and falls after the edge that sees SS_n=1.
- frame_err is high for exactly the cycle after that edge.
- MISO = 0 whenever not in RD_DATA.
- Pointer wrap: 2**ADDR_WIDTH-1 + 1 -> 0.

## Test plan
- Reset release with SS_n held low for 20 cycles -> busy=0, MISO=0, no memory change. Then SS_n high 1 cycle, low -> frame accepted.
- Defaults: WR_ADDR 0x10; WR_DATA 0xA5; RD_ADDR 0x10; RD_DATA -> MISO 1,0,1,0,0,1,0,1 after E4..E11, frame_err never pulses.
- Burst wrap: WR_ADDR 0xFE; one WR_DATA frame carrying 0x11,0x22,0x33 -> mem[FE]=11, mem[FF]=22, mem[00]=33. RD_ADDR 0xFE + RD_DATA for 24 bits -> 0x11,0x22,0x33 back-to-back with no gap.
- AUTO_INC=0, ADDR_WIDTH=4, DATA_WIDTH=16: burst 0x1234, 0xBEEF to address 3 -> mem[3]=0xBEEF, wr_ptr still 3. Burst read of 2 words -> 0xBEEF twice.
- Abort: WR_DATA frame raised after 5 payload bits -> frame_err=1 for one cycle, target word unchanged, wr_ptr unchanged. Raise after exactly 8 bits -> write occurs, no frame_err.
- rst_n low mid burst-read -> MISO=0 and busy=0 after that edge, pointers 0. A following WR_ADDR/RD sequence works normally.
